// File: rtl/uart_tx_sched_if.sv
// Signal bundle between the byte requesters / baud generator and uart_tx_sched.
interface uart_tx_sched_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] data_in;
    logic [NREQ-1:0]        ack;
    logic                   bps_start;
    logic                   bps_clk;
    logic                   txd;
    logic                   busy;
    logic [2:0]             grant_id;
    logic                   tx_done;

    modport master (
        output req, data_in, bps_clk,
        input  ack, bps_start, txd, busy, grant_id, tx_done
    );

    modport slave (
        input  req, data_in, bps_clk,
        output ack, bps_start, txd, busy, grant_id, tx_done
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler serialising one requester byte at a time onto a shared 8N1 UART line.
// Optional even-parity bit before the stop bit when TX_PARITY_EN is defined.
module uart_tx_sched #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 16
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5
`ifdef TX_PARITY_EN
        , PARITY = 3'd6
`endif
    } state_t;

    // First set request at or after the pointer, wrapping modulo NREQ.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [2:0] s;
        int         k;
        s = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(p) + i) % NREQ;
            s = r[k[IW-1:0]] ? k[2:0] : s;
        end
        return s;
    endfunction

`ifdef TX_PARITY_EN
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    state_t            state_r, state_s;
    logic [2:0]        ptr_r, ptr_s, sel_s;
    logic [DATA_W-1:0] shift_r, shift_s, byte_s;
    logic [NREQ-1:0]   onehot_s;
    logic [CW-1:0]     bit_cnt_r, bit_cnt_s;
    logic [GW-1:0]     gap_cnt_r, gap_cnt_s;
    logic [NREQ-1:0]   ack_r, ack_s;
    logic              bps_start_r, bps_start_s;
    logic              txd_r, txd_s;
    logic              busy_r, busy_s;
    logic              tx_done_r, tx_done_s;
    logic [2:0]        grant_id_r, grant_id_s;
`ifdef TX_PARITY_EN
    logic              par_r, par_s;
`endif

    // Round-robin winner with its byte and one-hot ack pattern.
    always_comb begin
        sel_s    = rr_pick(bus.req, ptr_r);
        byte_s   = '0;
        onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            byte_s      = (sel_s == 3'(i)) ? bus.data_in[i*DATA_W +: DATA_W] : byte_s;
            onehot_s[i] = (sel_s == 3'(i));
        end
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        ack_s       = '0;
        bps_start_s = bps_start_r;
        txd_s       = txd_r;
        busy_s      = busy_r;
        grant_id_s  = grant_id_r;
        tx_done_s   = 1'b0;
`ifdef TX_PARITY_EN
        par_s       = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (|bus.req) begin
                    ack_s       = onehot_s;
                    shift_s     = byte_s;
                    grant_id_s  = sel_s;
                    ptr_s       = (sel_s == 3'(NREQ - 1)) ? 3'd0 : sel_s + 3'd1;
                    busy_s      = 1'b1;
                    bps_start_s = 1'b1;
                    txd_s       = 1'b1;
`ifdef TX_PARITY_EN
                    par_s       = even_par(byte_s);
`endif
                    state_s     = LEAD;
                end else begin
                    state_s = IDLE;
                end
            end
            // Waiting for the first pulse makes every later bit exactly one pulse period long.
            LEAD: begin
                if (bus.bps_clk) begin
                    txd_s   = 1'b0;
                    state_s = START;
                end else begin
                    state_s = LEAD;
                end
            end
            START: begin
                if (bus.bps_clk) begin
                    txd_s     = shift_r[0];
                    bit_cnt_s = '0;
                    state_s   = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bus.bps_clk) begin
                    if (bit_cnt_r == CW'(DATA_W - 1)) begin
`ifdef TX_PARITY_EN
                        txd_s   = par_r;
                        state_s = PARITY;
`else
                        txd_s   = 1'b1;
                        state_s = STOP;
`endif
                    end else begin
                        shift_s   = shift_r >> 1;
                        bit_cnt_s = bit_cnt_r + CW'(1);
                        txd_s     = shift_r[1];
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bus.bps_clk) begin
                    txd_s   = 1'b1;
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bus.bps_clk) begin
                    bps_start_s = 1'b0;
                    tx_done_s   = 1'b1;
                    gap_cnt_s   = '0;
                    state_s     = GAP;
                end else begin
                    state_s = STOP;
                end
            end
            GAP: begin
                txd_s = 1'b1;
                if ((GAP_CYC == 0) || (gap_cnt_r == GW'(GAP_CYC - 1))) begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                txd_s       = 1'b1;
                bps_start_s = 1'b0;
                busy_s      = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the idle line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd0;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            ack_r       <= '0;
            bps_start_r <= 1'b0;
            txd_r       <= 1'b1;
            busy_r      <= 1'b0;
            grant_id_r  <= 3'd0;
            tx_done_r   <= 1'b0;
`ifdef TX_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            shift_r     <= shift_s;
            bit_cnt_r   <= bit_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            ack_r       <= ack_s;
            bps_start_r <= bps_start_s;
            txd_r       <= txd_s;
            busy_r      <= busy_s;
            grant_id_r  <= grant_id_s;
            tx_done_r   <= tx_done_s;
`ifdef TX_PARITY_EN
            par_r       <= par_s;
`endif
        end
    end

    assign bus.ack       = ack_r;
    assign bus.bps_start = bps_start_r;
    assign bus.txd       = txd_r;
    assign bus.busy      = busy_r;
    assign bus.grant_id  = grant_id_r;
    assign bus.tx_done   = tx_done_r;
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler sharing one UART transmit line among NREQ byte requesters.
- Sequences the shared baud generator: drives bps_start and consumes its mid-period bps_clk pulse.
- Serialises the granted byte onto txd as 8N1, LSB first.
- Sits between application producers (sensor/status/command senders) and the board UART pin.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, bits per character.
- GAP_CYC, 16, idle clocks forced on txd between frames (0 allowed).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NREQ  per-requester send request; level, held until matching ack bit.
- data_in  input  NREQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]; stable while req[i]=1.
- ack  output  NREQ  one-cycle pulse; byte of that requester has been latched.
- bps_start  output  1  run enable to baud generator.
- bps_clk  input  1  one-cycle pulse from baud generator, once per bit period while bps_start=1.
- txd  output  1  serial line, idle high.
- busy  output  1  high from grant to end of gap.
- grant_id  output  3  index of the current or last granted requester.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset values: txd=1, bps_start=0, ack=0, busy=0, grant_id=0, tx_done=0, RR pointer=0, state IDLE.
- States: IDLE, LEAD, START, DATA, STOP, GAP.
- IDLE:
  - If any req bit is set, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - Next cycle: latch that byte into the shift register, pulse ack[sel] for one cycle, set grant_id=sel, set pointer=(sel+1) mod NREQ.
  - Then busy=1, bps_start=1, go to LEAD.
  - Arbitration happens only in IDLE. Requests arriving in any other state wait.
- LEAD:
  - txd stays 1 until the first bps_clk.
  - This aligns bit edges to pulses, so every bit is exactly one pulse period long.
  - On bps_clk: txd=0, go to START.
- START: on bps_clk, txd=shift[0], bit counter=0, go to DATA.
- DATA:
  - On each bps_clk: shift right, increment counter, drive the next bit.
  - After bit DATA_W-1 has lasted one period, txd=1 and go to STOP.
- STOP: on bps_clk, bps_start=0, pulse tx_done, go to GAP.
- GAP:
  - txd=1; count GAP_CYC clocks, then busy=0 and go to IDLE.
  - GAP_CYC=0 goes straight to IDLE on the next cycle.
- bps_clk is ignored whenever bps_start=0 or state is IDLE/GAP.
- bps_start is held continuously from LEAD through STOP, so the generator is never restarted mid-frame.
- req[i] dropped before its ack: no effect if not yet granted. After grant, the frame completes regardless.
- Only one ack bit is ever set in a cycle.
- Reset asserted mid-frame: immediate return to reset values; txd goes high (partial frame truncated).
- Frame duration with a 434-clock bit period: LEAD ~218 clocks, then (2+DATA_W)*434 clocks.

Optional Feature:
- Macro TX_PARITY_EN.
- Defined: an even-parity bit is inserted between the last data bit and stop, in an extra PARITY state lasting one bps_clk period. Parity = XOR of the latched byte. Frame becomes 11 bits.
- Undefined: no PARITY state exists and frames are 8N1.

Test Plan:
- Single request: req=0001, data0=0x55, bit period 434 -> ack[0] one cycle after req. txd falls at the first bps_clk. txd reads 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop) at 434-clock spacing. tx_done at stop end; busy drops GAP_CYC=16 clocks later.
- Contention: req=1111 held, distinct bytes -> grants in order 0,1,2,3,0. Pointer wraps. Each ack precedes its frame.
- Pointer fairness: req=0101 continuously -> grants alternate 0,2,0,2; requester 2 is never starved.
- Late request: req[3] raised mid-frame of requester 1 -> no ack until the next IDLE. req[3] is granted next if the pointer is at 2 or 3.
- Reset mid-DATA: assert rst at bit 4 -> txd=1, bps_start=0, busy=0 the same cycle. After release, a fresh req=0010 is granted with pointer=0 semantics.
- TX_PARITY_EN defined, data 0x07 -> parity bit 1 before stop; 11-bit frame of 4774 clocks after LEAD.
